// File: rtl/ast_arb_mux_pkg.sv
// Shared constants, FSM state encodings and drop-counter helpers for the
// round-robin Avalon-ST packet multiplexer.
package ast_arb_mux_pkg;

    localparam int DATA_WIDTH_DEF    = 64;
    localparam int CHANNEL_WIDTH_DEF = 8;
    localparam int RX_DIR_DEF        = 4;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    function automatic logic [5:0] popcount32(input logic [31:0] vec);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, vec[i]};
        end
        return cnt;
    endfunction

    // Saturating add keeps the drop counter pinned at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [5:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {11'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/ast_rr_arb.sv
// Round-robin request arbiter: combinational scan from the pointer upwards
// with wrap, plus the pointer register that moves past the last winner.
module ast_rr_arb
    import ast_arb_mux_pkg::*;
#(
    parameter int N     = RX_DIR_DEF,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             adv,
    input  logic [IDX_W-1:0] adv_idx,
    output logic             grant_vld,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N-1:0]     grant_oh
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_nxt_s;

    // First requester found at or above the pointer wins.
    always_comb begin
        int cand;
        grant_vld = 1'b0;
        grant_idx = {IDX_W{1'b0}};
        grant_oh  = {N{1'b0}};
        cand      = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_r) + i;
            if (cand >= N) begin
                cand = cand - N;
            end else begin
                cand = cand;
            end
            if (!grant_vld && req[cand]) begin
                grant_vld      = 1'b1;
                grant_idx      = IDX_W'(cand);
                grant_oh[cand] = 1'b1;
            end else begin
                grant_vld = grant_vld;
            end
        end
    end

    // With a single input this always evaluates to zero, pinning the pointer.
    assign ptr_nxt_s = (int'(adv_idx) >= N - 1) ? {IDX_W{1'b0}} : IDX_W'(int'(adv_idx) + 1);

    // Pointer moves just past the input whose packet has completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {IDX_W{1'b0}};
        end else if (adv) begin
            ptr_r <= ptr_nxt_s;
        end
    end

endmodule

// File: rtl/ast_arb_mux.sv
// Packet-level round-robin Avalon-ST multiplexer with one output register stage.
// Optional stray-beat dropping and drop counter: define AST_ARB_MUX_STRAY_DROP_EN.
module ast_arb_mux
    import ast_arb_mux_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int CHANNEL_WIDTH = CHANNEL_WIDTH_DEF,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
    parameter int RX_DIR        = RX_DIR_DEF,
    parameter int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
    input  logic                                  clk_i,
    input  logic                                  arst_n_i,
    input  logic [RX_DIR-1:0][DATA_WIDTH-1:0]     ast_data_i,
    input  logic [RX_DIR-1:0]                     ast_startofpacket_i,
    input  logic [RX_DIR-1:0]                     ast_endofpacket_i,
    input  logic [RX_DIR-1:0]                     ast_valid_i,
    input  logic [RX_DIR-1:0][EMPTY_WIDTH-1:0]    ast_empty_i,
    input  logic [RX_DIR-1:0][CHANNEL_WIDTH-1:0]  ast_channel_i,
    output logic [RX_DIR-1:0]                     ast_ready_o,
    output logic [DATA_WIDTH-1:0]                 ast_data_o,
    output logic                                  ast_startofpacket_o,
    output logic                                  ast_endofpacket_o,
    output logic                                  ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]                ast_empty_o,
    output logic [CHANNEL_WIDTH-1:0]              ast_channel_o,
    input  logic                                  ast_ready_i,
    output logic [DIR_SEL_WIDTH-1:0]              ast_dir_o
`ifdef AST_ARB_MUX_STRAY_DROP_EN
    ,
    output logic [15:0]                           drop_cnt_o
`endif
);

    logic [0:0]               state_r, state_nxt_s;
    logic [DIR_SEL_WIDTH-1:0] sel_r, sel_nxt_s, beat_idx_s, grant_idx_s, adv_idx_s;
    logic [RX_DIR-1:0]        req_s, grant_oh_s, ready_s;
    logic                     grant_vld_s, accept_s, load_s, adv_s;

    logic [DATA_WIDTH-1:0]    data_r;
    logic                     sop_r, eop_r, valid_r;
    logic [EMPTY_WIDTH-1:0]   empty_r;
    logic [CHANNEL_WIDTH-1:0] channel_r;
    logic [DIR_SEL_WIDTH-1:0] dir_r;

    assign load_s = !valid_r || ast_ready_i;
    assign req_s  = ast_valid_i & ast_startofpacket_i;

    ast_rr_arb #(
        .N     (RX_DIR),
        .IDX_W (DIR_SEL_WIDTH)
    ) u_rr_arb (
        .clk       (clk_i),
        .rst_n     (arst_n_i),
        .req       (req_s),
        .adv       (adv_s),
        .adv_idx   (adv_idx_s),
        .grant_vld (grant_vld_s),
        .grant_idx (grant_idx_s),
        .grant_oh  (grant_oh_s)
    );

    // Ownership FSM: grant on SOP, hold the owner until its EOP transfers.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        ready_s     = {RX_DIR{1'b0}};
        accept_s    = 1'b0;
        beat_idx_s  = sel_r;
        adv_s       = 1'b0;
        adv_idx_s   = sel_r;
        case (state_r)
            ST_IDLE: begin
                beat_idx_s = grant_idx_s;
                adv_idx_s  = grant_idx_s;
                if (grant_vld_s && load_s) begin
                    ready_s  = grant_oh_s;
                    accept_s = 1'b1;
                    if (ast_endofpacket_i[grant_idx_s]) begin
                        adv_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_LOCKED;
                        sel_nxt_s   = grant_idx_s;
                    end
                end else begin
                    ready_s = {RX_DIR{1'b0}};
                end
            end
            ST_LOCKED: begin
                ready_s[sel_r] = load_s;
                accept_s       = ast_valid_i[sel_r] && load_s;
                if (accept_s && ast_endofpacket_i[sel_r]) begin
                    state_nxt_s = ST_IDLE;
                    adv_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

`ifdef AST_ARB_MUX_STRAY_DROP_EN
    logic [RX_DIR-1:0] drop_s;
    logic [15:0]       drop_cnt_r;

    assign drop_s      = (state_r == ST_IDLE) ? (ast_valid_i & ~ast_startofpacket_i) : {RX_DIR{1'b0}};
    assign ast_ready_o = (ready_s | drop_s) & {RX_DIR{arst_n_i}};
    assign drop_cnt_o  = drop_cnt_r;

    // Counts discarded mid-packet beats seen while no packet is owned.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            drop_cnt_r <= 16'h0000;
        end else begin
            drop_cnt_r <= sat_add16(drop_cnt_r, popcount32(32'(drop_s)));
        end
    end
`else
    // Ready is forced low while reset is asserted so no source sees a transfer.
    assign ast_ready_o = ready_s & {RX_DIR{arst_n_i}};
`endif

    // FSM state and owning input.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r <= ST_IDLE;
            sel_r   <= {DIR_SEL_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
        end
    end

    // Output register: loads whenever empty or draining, otherwise holds.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            valid_r   <= 1'b0;
            data_r    <= {DATA_WIDTH{1'b0}};
            sop_r     <= 1'b0;
            eop_r     <= 1'b0;
            empty_r   <= {EMPTY_WIDTH{1'b0}};
            channel_r <= {CHANNEL_WIDTH{1'b0}};
            dir_r     <= {DIR_SEL_WIDTH{1'b0}};
        end else if (load_s) begin
            valid_r <= accept_s;
            if (accept_s) begin
                data_r    <= ast_data_i[beat_idx_s];
                sop_r     <= ast_startofpacket_i[beat_idx_s];
                eop_r     <= ast_endofpacket_i[beat_idx_s];
                empty_r   <= ast_empty_i[beat_idx_s];
                channel_r <= ast_channel_i[beat_idx_s];
                dir_r     <= beat_idx_s;
            end
        end
    end

    assign ast_valid_o         = valid_r;
    assign ast_data_o          = data_r;
    assign ast_startofpacket_o = sop_r;
    assign ast_endofpacket_o   = eop_r;
    assign ast_empty_o         = empty_r;
    assign ast_channel_o       = channel_r;
    assign ast_dir_o           = dir_r;

endmodule

// File: tb/tb_ast_arb_mux.sv
// Directed self-checking bench for ast_arb_mux (4 inputs, 64-bit data).
module tb_ast_arb_mux;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int EW = 3;
    localparam int N  = 4;
    localparam int SW = 2;

    logic                 clk = 1'b0;
    logic                 arst_n;
    logic [N-1:0][DW-1:0] ast_data_i;
    logic [N-1:0]         ast_startofpacket_i, ast_endofpacket_i, ast_valid_i;
    logic [N-1:0][EW-1:0] ast_empty_i;
    logic [N-1:0][CW-1:0] ast_channel_i;
    logic [N-1:0]         ast_ready_o;
    logic [DW-1:0]        ast_data_o;
    logic                 ast_startofpacket_o, ast_endofpacket_o, ast_valid_o;
    logic [EW-1:0]        ast_empty_o;
    logic [CW-1:0]        ast_channel_o;
    logic                 ast_ready_i;
    logic [SW-1:0]        ast_dir_o;
`ifdef AST_ARB_MUX_STRAY_DROP_EN
    logic [15:0]          drop_cnt;
`endif

    ast_arb_mux dut (
        .clk_i               (clk),
        .arst_n_i            (arst_n),
        .ast_data_i          (ast_data_i),
        .ast_startofpacket_i (ast_startofpacket_i),
        .ast_endofpacket_i   (ast_endofpacket_i),
        .ast_valid_i         (ast_valid_i),
        .ast_empty_i         (ast_empty_i),
        .ast_channel_i       (ast_channel_i),
        .ast_ready_o         (ast_ready_o),
        .ast_data_o          (ast_data_o),
        .ast_startofpacket_o (ast_startofpacket_o),
        .ast_endofpacket_o   (ast_endofpacket_o),
        .ast_valid_o         (ast_valid_o),
        .ast_empty_o         (ast_empty_o),
        .ast_channel_o       (ast_channel_o),
        .ast_ready_i         (ast_ready_i),
`ifdef AST_ARB_MUX_STRAY_DROP_EN
        .drop_cnt_o          (drop_cnt),
`endif
        .ast_dir_o           (ast_dir_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [7:0]  chan;
    } beat_t;

    beat_t        mem [N][8];
    int           cnt [N];
    int           ptr [N];
    logic [N-1:0] gap;
    logic [N-1:0] rdy_snap;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int dir, input logic [63:0] d,
                            input logic sop, input logic eop);
        chk({tag, "_valid"}, 64'(ast_valid_o), 64'd1);
        chk({tag, "_dir"}, 64'(ast_dir_o), 64'(dir));
        chk({tag, "_data"}, ast_data_o, d);
        chk({tag, "_sop"}, 64'(ast_startofpacket_o), 64'(sop));
        chk({tag, "_eop"}, 64'(ast_endofpacket_o), 64'(eop));
    endtask

    task automatic clr_src();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            ptr[i] = 0;
        end
        gap = 4'b0000;
    endtask

    task automatic push_beat(input int i, input logic [63:0] d, input logic sop, input logic eop,
                             input logic [2:0] e, input logic [7:0] ch);
        mem[i][cnt[i]].data  = d;
        mem[i][cnt[i]].sop   = sop;
        mem[i][cnt[i]].eop   = eop;
        mem[i][cnt[i]].empty = e;
        mem[i][cnt[i]].chan  = ch;
        cnt[i]++;
    endtask

    task automatic load_pkt(input int i, input int n, input logic [63:0] base, input logic [2:0] e_last);
        for (int k = 0; k < n; k++) begin
            push_beat(i, base + 64'(k), k == 0, k == n - 1, (k == n - 1) ? e_last : 3'd0, 8'(i));
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (ptr[i] < cnt[i] && !gap[i]) begin
                ast_valid_i[i]         = 1'b1;
                ast_data_i[i]          = mem[i][ptr[i]].data;
                ast_startofpacket_i[i] = mem[i][ptr[i]].sop;
                ast_endofpacket_i[i]   = mem[i][ptr[i]].eop;
                ast_empty_i[i]         = mem[i][ptr[i]].empty;
                ast_channel_i[i]       = mem[i][ptr[i]].chan;
            end else begin
                ast_valid_i[i]         = 1'b0;
                ast_data_i[i]          = 64'd0;
                ast_startofpacket_i[i] = 1'b0;
                ast_endofpacket_i[i]   = 1'b0;
                ast_empty_i[i]         = 3'd0;
                ast_channel_i[i]       = 8'd0;
            end
        end
    endtask

    // One clock: present source beats, note handshakes, advance accepted sources.
    task automatic cycle();
        logic [N-1:0] fired;
        drive();
        #1;
        rdy_snap = ast_ready_o;
        fired    = ast_valid_i & ast_ready_o;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fired[i]) ptr[i]++;
        end
    endtask

    initial begin
        arst_n      = 1'b0;
        ast_ready_i = 1'b1;
        clr_src();
        drive();
        #12;
        chk("rst_valid", 64'(ast_valid_o), 64'd0);
        chk("rst_data", ast_data_o, 64'd0);
        chk("rst_dir", 64'(ast_dir_o), 64'd0);
        chk("rst_ready", 64'(ast_ready_o), 64'd0);
        #10;
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four simultaneous 3-beat packets: back-to-back in order 0,1,2,3.
        for (int i = 0; i < N; i++) load_pkt(i, 3, 64'h1000 * 64'(i + 1), 3'd0);
        for (int k = 1; k <= 12; k++) begin
            int p, b;
            cycle();
            p = (k - 1) / 3;
            b = (k - 1) % 3;
            chk_beat($sformatf("t1_b%0d", k), p, 64'h1000 * 64'(p + 1) + 64'(b), b == 0, b == 2);
            chk($sformatf("t1_chan%0d", k), 64'(ast_channel_o), 64'(p));
            if (k == 2) chk("t1_lock_ready", 64'(rdy_snap), 64'h1);
        end
        cycle();
        chk("t1_idle_valid", 64'(ast_valid_o), 64'd0);

        // Single-beat packet on 2 moves the pointer to 3, so 1 beats 2 next.
        clr_src();
        load_pkt(2, 1, 64'h2000, 3'd5);
        load_pkt(2, 2, 64'h2100, 3'd0);
        cycle();
        chk_beat("t2_single", 2, 64'h2000, 1'b1, 1'b1);
        chk("t2_empty", 64'(ast_empty_o), 64'd5);
        load_pkt(1, 2, 64'h2200, 3'd0);
        cycle();
        chk("t2_ready", 64'(rdy_snap), 64'h2);
        chk_beat("t2_in1_b0", 1, 64'h2200, 1'b1, 1'b0);
        cycle();
        chk_beat("t2_in1_b1", 1, 64'h2201, 1'b0, 1'b1);
        cycle();
        chk_beat("t2_in2_b0", 2, 64'h2100, 1'b1, 1'b0);
        cycle();
        chk_beat("t2_in2_b1", 2, 64'h2101, 1'b0, 1'b1);

        // Downstream back-pressure 1,0,0,1 in the middle of a 4-beat packet.
        clr_src();
        load_pkt(0, 4, 64'h3000, 3'd2);
        ast_ready_i = 1'b1;
        cycle();
        chk_beat("t3_b0", 0, 64'h3000, 1'b1, 1'b0);
        cycle();
        chk_beat("t3_b1", 0, 64'h3001, 1'b0, 1'b0);
        ast_ready_i = 1'b0;
        cycle();
        chk("t3_hold_ready", 64'(rdy_snap), 64'h0);
        chk_beat("t3_hold1", 0, 64'h3001, 1'b0, 1'b0);
        cycle();
        chk_beat("t3_hold2", 0, 64'h3001, 1'b0, 1'b0);
        ast_ready_i = 1'b1;
        cycle();
        chk_beat("t3_b2", 0, 64'h3002, 1'b0, 1'b0);
        cycle();
        chk_beat("t3_b3", 0, 64'h3003, 1'b0, 1'b1);
        chk("t3_empty", 64'(ast_empty_o), 64'd2);
        cycle();
        chk("t3_drained", 64'(ast_valid_o), 64'd0);

        // Owner stalls for 2 cycles while input 3 waits with SOP pending.
        clr_src();
        load_pkt(0, 4, 64'h4000, 3'd0);
        cycle();
        chk_beat("t4_b0", 0, 64'h4000, 1'b1, 1'b0);
        load_pkt(3, 2, 64'h4100, 3'd0);
        gap[0] = 1'b1;
        cycle();
        chk("t4_bub1_ready", 64'(rdy_snap), 64'h1);
        chk("t4_bub1_valid", 64'(ast_valid_o), 64'd0);
        cycle();
        chk("t4_bub2_ready", 64'(rdy_snap), 64'h1);
        chk("t4_bub2_valid", 64'(ast_valid_o), 64'd0);
        gap[0] = 1'b0;
        cycle();
        chk_beat("t4_b1", 0, 64'h4001, 1'b0, 1'b0);
        cycle();
        chk_beat("t4_b2", 0, 64'h4002, 1'b0, 1'b0);
        cycle();
        chk_beat("t4_b3", 0, 64'h4003, 1'b0, 1'b1);
        cycle();
        chk_beat("t4_in3_b0", 3, 64'h4100, 1'b1, 1'b0);
        cycle();
        chk_beat("t4_in3_b1", 3, 64'h4101, 1'b0, 1'b1);

        // Asynchronous reset pulse between edges truncates the packet.
        clr_src();
        load_pkt(0, 4, 64'h5000, 3'd0);
        cycle();
        cycle();
        chk_beat("t5_b1", 0, 64'h5001, 1'b0, 1'b0);
        #2;
        arst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(ast_valid_o), 64'd0);
        chk("t5_rst_data", ast_data_o, 64'd0);
        chk("t5_rst_eop", 64'(ast_endofpacket_o), 64'd0);
        chk("t5_rst_ready", 64'(ast_ready_o), 64'd0);
        #1;
        arst_n = 1'b1;
        clr_src();
        load_pkt(2, 2, 64'h5100, 3'd0);
        cycle();
        chk_beat("t5_new_b0", 2, 64'h5100, 1'b1, 1'b0);
        cycle();
        chk_beat("t5_new_b1", 2, 64'h5101, 1'b0, 1'b1);

        // Mid-packet beats arriving with no owner.
        clr_src();
        for (int k = 0; k < 3; k++) push_beat(1, 64'h6000 + 64'(k), 1'b0, 1'b0, 3'd0, 8'd1);
`ifdef AST_ARB_MUX_STRAY_DROP_EN
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("t6_drop_ready%0d", k), 64'(rdy_snap), 64'h2);
            chk($sformatf("t6_drop_valid%0d", k), 64'(ast_valid_o), 64'd0);
        end
        cycle();
        chk("t6_drop_cnt", 64'(drop_cnt), 64'd3);
        chk("t6_drop_valid_end", 64'(ast_valid_o), 64'd0);
`else
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("t6_hold_ready%0d", k), 64'(rdy_snap), 64'h0);
            chk($sformatf("t6_hold_valid%0d", k), 64'(ast_valid_o), 64'd0);
        end
`endif
        clr_src();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
